pixel_array_controller: RTL and testbench
=========================================

Name: pixel_array_controller

Overview:
- Frame-level sequencer that drives the pixel array's ERASE, EXPOSE, RAMP and COUNTER lines and the per-row READ strobes.
- Captures each row from the shared DATA bus into a row buffer and streams pixels out one per cycle over a valid/ready interface.
- Sits between the PIXEL_SENSOR array and the downstream frame sink (packer/output interface).
- One frame per `start` pulse.

Parameters:
- PIXEL_BITS, 8, bits per pixel; COUNTER, RAMP step count = 2**PIXEL_BITS.
- ARRAY_WIDTH, 2, pixels per row (columns sharing one READ line).
- ARRAY_HEIGHT, 2, number of rows (one READ line each).
- ERASE_CYCLES, 5, clk cycles ERASE is held high (>=1).
- EXPOSE_CYCLES, 255, clk cycles EXPOSE is held high (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a frame; sampled only in IDLE.
- erase  out  1  to all pixels' ERASE.
- expose  out  1  to all pixels' EXPOSE; sensor's VBN1 is driven from clk externally.
- ramp  out  1  to all pixels' RAMP; registered.
- counter  out  PIXEL_BITS  to all pixels' COUNTER; registered.
- read_row  out  ARRAY_HEIGHT  one-hot-or-zero row READ enables.
- row_data  in  ARRAY_WIDTH*PIXEL_BITS  concatenated DATA buses of the selected row; column 0 in LSBs.
- pix_valid  out  1  pixel stream valid.
- pix_ready  in  1  pixel stream ready from sink.
- pix_data  out  PIXEL_BITS  pixel value.
- pix_last  out  1  high with the final pixel of the frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0: erase, expose, ramp, counter, read_row, pix_valid, pix_data, pix_last, busy. Row buffer contents don't-care.
- FSM states: IDLE, ERASE, EXPOSE, CONVERT, READ_SETTLE, READ_CAPTURE, STREAM, with a single down/up phase counter shared across states.
- IDLE: start=1 -> ERASE next cycle. start is ignored in every other state (no queuing).
- ERASE: erase=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: expose=1 for exactly EXPOSE_CYCLES cycles, then CONVERT.
- CONVERT:
  - Lasts 2*2**PIXEL_BITS cycles.
  - ramp toggles every cycle, starting at 1 on the first CONVERT cycle.
  - counter starts at 0 on entry and increments by 1 on each cycle in which ramp goes 1->0.
  - counter is therefore stable across every ramp rising edge; value k is present at the (k+1)th ramp rise.
  - After the final cycle: ramp=0, counter held at 2**PIXEL_BITS-1 (no wrap to 0).
  - Then go to READ_SETTLE with row index r=0.
- READ_SETTLE: read_row[r]=1 for one cycle to allow bus settle.
- READ_CAPTURE:
  - read_row[r] stays 1.
  - row_data is registered into the row buffer (ARRAY_WIDTH entries).
  - Next cycle: read_row=0, column index c=0, state STREAM.
- STREAM:
  - pix_valid=1, pix_data=buffer[c].
  - pix_data, pix_valid and pix_last must remain stable while pix_valid && !pix_ready.
  - On a pix_valid && pix_ready cycle, c increments.
  - After column ARRAY_WIDTH-1: if r<ARRAY_HEIGHT-1, go to READ_SETTLE with r+1; else go to IDLE.
  - Back-to-back transfers within a row run one pixel per cycle.
  - 2 idle cycles of pix_valid=0 between rows.
- pix_last=1 only with row ARRAY_HEIGHT-1, column ARRAY_WIDTH-1.
- read_row must never have more than one bit set; it is zero outside READ_SETTLE/READ_CAPTURE.
- Reset mid-frame: immediate return to IDLE with all outputs 0. No partial-frame completion is required.
- counter is only updated in CONVERT. Its value is retained in other states until the next CONVERT entry resets it to 0.

Decomposition:
- Shared package (pixel_sensor configuration): PIXEL_BITS, PIXEL_ARRAY_WIDTH, PIXEL_ARRAY_HEIGHT defaults.
- FSM state enum type ctrl_state_t in the same package for bench visibility.
- One natural sub-module, pixel_row_buffer: captures row_data and provides the indexed, held output with its valid/ready register.

Test Plan:
- Reset then idle: start=0 for 100 cycles -> busy=0, all outputs 0, no read_row activity.
- Single frame, defaults, pix_ready=1:
  - erase high 5 cycles, then expose high 255 cycles.
  - CONVERT lasts 512 cycles; counter reaches 255 and holds.
  - Exactly 4 pixel transfers; pix_last on the 4th only.
- Data path: drive row_data=16'hB0A0 when read_row[0] and 16'hD0C0 when read_row[1] -> stream A0, B0, C0, D0.
- Backpressure: pix_ready low for 3 cycles on the 2nd pixel -> pix_data holds B0, no duplication or loss, still 4 transfers.
- Ramp/counter alignment: log counter at each ramp rise -> values 0..255 in order, 256 rising edges total.
- Reset during CONVERT (counter=100) -> all outputs 0 immediately; a new start runs a complete correct frame.

Source files
------------

// File: rtl/pixel_array_controller_pkg.sv
// pixel_array_controller_pkg: shared pixel sensor configuration and controller state type
package pixel_array_controller_pkg;
    localparam int PIXEL_BITS = 8;
    localparam int PIXEL_ARRAY_WIDTH = 2;
    localparam int PIXEL_ARRAY_HEIGHT = 2;
    localparam int ERASE_CYCLES = 5;
    localparam int EXPOSE_CYCLES = 255;
    localparam int PHASE_W = 16;
    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ_SETTLE,
        READ_CAPTURE,
        STREAM
    } ctrl_state_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pixel_array_controller_if.sv
// pixel_array_controller_if: valid/ready pixel stream towards the frame sink
interface pixel_array_controller_if #(parameter int PIXEL_BITS = pixel_array_controller_pkg::PIXEL_BITS);
    logic                  valid;
    logic                  ready;
    logic                  last;
    logic [PIXEL_BITS-1:0] data;
    modport master (output valid, output data, output last, input ready);
    modport slave (input valid, input data, input last, output ready);
endinterface

// File: rtl/pixel_array_controller_row_buffer.sv
// pixel_row_buffer: captures one row from the DATA bus and streams it out with held valid/data/last
module pixel_row_buffer #(
    parameter int PIXEL_BITS  = pixel_array_controller_pkg::PIXEL_BITS,
    parameter int ARRAY_WIDTH = pixel_array_controller_pkg::PIXEL_ARRAY_WIDTH
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              capture,
    input  logic                              last_row,
    input  logic [ARRAY_WIDTH*PIXEL_BITS-1:0] row_data,
    output logic                              row_done,
    pixel_array_controller_if.master          pix
);
    import pixel_array_controller_pkg::*;
    localparam int COL_W = idx_w(ARRAY_WIDTH);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ARRAY_WIDTH - 1);
    logic [PIXEL_BITS-1:0] buf_q [ARRAY_WIDTH];
    logic [PIXEL_BITS-1:0] buf_d [ARRAY_WIDTH];
    logic [COL_W-1:0]      col_q, col_d, col_n;
    logic                  valid_q, valid_d, last_q, last_d, last_row_q, last_row_d;
    logic [PIXEL_BITS-1:0] data_q, data_d;
    assign col_n = col_q + COL_W'(1);
    assign row_done = valid_q && pix.ready && col_q == LAST_COL;
    assign pix.valid = valid_q;
    assign pix.data = data_q;
    assign pix.last = last_q;
    always_comb begin
        buf_d = buf_q;
        col_d = col_q;
        valid_d = valid_q;
        data_d = data_q;
        last_d = last_q;
        last_row_d = last_row_q;
        if (capture) begin
            for (int i = 0; i < ARRAY_WIDTH; i++) buf_d[i] = row_data[i*PIXEL_BITS +: PIXEL_BITS];
            col_d = '0;
            valid_d = 1'b1;
            data_d = row_data[PIXEL_BITS-1:0];
            last_row_d = last_row;
            last_d = last_row && (ARRAY_WIDTH == 1);
        end else if (valid_q && pix.ready) begin
            valid_d = col_q != LAST_COL;
            col_d = col_q == LAST_COL ? col_q : col_n;
            data_d = col_q == LAST_COL ? '0 : buf_q[col_n];
            last_d = col_q != LAST_COL && last_row_q && col_n == LAST_COL;
        end
    end
    always_ff @(posedge clk) buf_q <= buf_d;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q <= '0;
            valid_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            last_row_q <= 1'b0;
        end else begin
            col_q <= col_d;
            valid_q <= valid_d;
            data_q <= data_d;
            last_q <= last_d;
            last_row_q <= last_row_d;
        end
    end
endmodule

// File: rtl/pixel_array_controller.sv
// pixel_array_controller: frame sequencer (erase/expose/ramp-convert/row read) feeding a pixel stream
module pixel_array_controller #(
    parameter int PIXEL_BITS    = pixel_array_controller_pkg::PIXEL_BITS,
    parameter int ARRAY_WIDTH   = pixel_array_controller_pkg::PIXEL_ARRAY_WIDTH,
    parameter int ARRAY_HEIGHT  = pixel_array_controller_pkg::PIXEL_ARRAY_HEIGHT,
    parameter int ERASE_CYCLES  = pixel_array_controller_pkg::ERASE_CYCLES,
    parameter int EXPOSE_CYCLES = pixel_array_controller_pkg::EXPOSE_CYCLES
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    output logic                              erase,
    output logic                              expose,
    output logic                              ramp,
    output logic [PIXEL_BITS-1:0]             counter,
    output logic [ARRAY_HEIGHT-1:0]           read_row,
    input  logic [ARRAY_WIDTH*PIXEL_BITS-1:0] row_data,
    output logic                              busy,
    pixel_array_controller_if.master          pix
);
    import pixel_array_controller_pkg::*;
    localparam int ROW_W = idx_w(ARRAY_HEIGHT);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_HEIGHT - 1);
    localparam logic [PIXEL_BITS-1:0] CNT_MAX = '1;
    localparam logic [PHASE_W-1:0] CONVERT_LAST = PHASE_W'(2 * (2 ** PIXEL_BITS) - 1);
    ctrl_state_t             state_q, state_d;
    logic [PHASE_W-1:0]      phase_q, phase_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic                    erase_q, erase_d, expose_q, expose_d, ramp_q, ramp_d, busy_q, busy_d;
    logic [PIXEL_BITS-1:0]   counter_q, counter_d;
    logic [ARRAY_HEIGHT-1:0] read_row_q, read_row_d;
    logic                    phase_done, row_done;
    assign phase_done = phase_q == '0;
    assign erase = erase_q;
    assign expose = expose_q;
    assign ramp = ramp_q;
    assign counter = counter_q;
    assign read_row = read_row_q;
    assign busy = busy_q;
    always_comb begin
        state_d = state_q;
        phase_d = phase_q - PHASE_W'(1);
        row_d = row_q;
        ramp_d = 1'b0;
        counter_d = counter_q;
        case (state_q)
            IDLE: begin
                state_d = start ? ERASE : IDLE;
                phase_d = PHASE_W'(ERASE_CYCLES - 1);
            end
            ERASE: if (phase_done) begin
                state_d = EXPOSE;
                phase_d = PHASE_W'(EXPOSE_CYCLES - 1);
            end
            EXPOSE: if (phase_done) begin
                state_d = CONVERT;
                phase_d = CONVERT_LAST;
                ramp_d = 1'b1;
                counter_d = '0;
            end
            CONVERT: if (phase_done) begin
                state_d = READ_SETTLE;
                row_d = '0;
            end else begin
                ramp_d = !ramp_q;
                counter_d = (ramp_q && counter_q != CNT_MAX) ? counter_q + PIXEL_BITS'(1) : counter_q;
            end
            READ_SETTLE: state_d = READ_CAPTURE;
            READ_CAPTURE: state_d = STREAM;
            STREAM: if (row_done) begin
                state_d = row_q == LAST_ROW ? IDLE : READ_SETTLE;
                row_d = row_q + ROW_W'(1);
            end
            default: state_d = IDLE;
        endcase
        erase_d = state_d == ERASE;
        expose_d = state_d == EXPOSE;
        busy_d = state_d != IDLE;
        read_row_d = (state_d == READ_SETTLE || state_d == READ_CAPTURE) ? ARRAY_HEIGHT'(1) << row_d : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            row_q <= '0;
            erase_q <= 1'b0;
            expose_q <= 1'b0;
            ramp_q <= 1'b0;
            counter_q <= '0;
            read_row_q <= '0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            row_q <= row_d;
            erase_q <= erase_d;
            expose_q <= expose_d;
            ramp_q <= ramp_d;
            counter_q <= counter_d;
            read_row_q <= read_row_d;
            busy_q <= busy_d;
        end
    end
    pixel_row_buffer #(.PIXEL_BITS(PIXEL_BITS), .ARRAY_WIDTH(ARRAY_WIDTH)) u_row_buffer (
        .clk      (clk),
        .reset_n  (reset_n),
        .capture  (state_q == READ_CAPTURE),
        .last_row (row_q == LAST_ROW),
        .row_data (row_data),
        .row_done (row_done),
        .pix      (pix)
    );
endmodule

// File: tb/tb_pixel_array_controller.sv
// tb_pixel_array_controller: directed frame vectors plus reset corner sequences
module tb_pixel_array_controller;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        erase, expose, ramp, busy;
    logic [7:0]  counter;
    logic [1:0]  read_row;
    logic [15:0] row_data;
    logic [15:0] r0 = 16'h0;
    logic [15:0] r1 = 16'h0;
    pixel_array_controller_if pif();
    pixel_array_controller dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .erase    (erase),
        .expose   (expose),
        .ramp     (ramp),
        .counter  (counter),
        .read_row (read_row),
        .row_data (row_data),
        .busy     (busy),
        .pix      (pif)
    );
    always #5 clk = ~clk;
    assign row_data = read_row[0] ? r0 : read_row[1] ? r1 : 16'h0;
    typedef struct {
        string       name;
        logic [15:0] r0;
        logic [15:0] r1;
        int          spx;
        int          sn;
        logic [7:0]  e0, e1, e2, e3;
    } vec_t;
    vec_t vecs[4];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0, erase_n = 0, expose_n = 0, n_xfer = 0, onehot_bad = 0, hold_bad = 0;
    int first_ramp = -1, first_rr = -1, rises = 0, rise_bad = 0;
    int stall_px = -1, stall_left = 0;
    int xcyc[4];
    logic [7:0] xdata[4];
    logic [3:0] xlast = 4'h0;
    logic       ramp_prev = 1'b0, held = 1'b0, held_last = 1'b0;
    logic [7:0] held_data = 8'h0;
    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    function automatic int outs_now();
        return int'({erase, expose, ramp, counter, read_row, pif.valid, pif.data, pif.last, busy});
    endfunction
    always @(negedge clk) begin
        cyc++;
        erase_n += int'(erase);
        expose_n += int'(expose);
        if ($countones(read_row) > 1) onehot_bad++;
        if (ramp && !ramp_prev) begin
            if (int'(counter) != rises) rise_bad++;
            rises++;
            if (first_ramp < 0) first_ramp = cyc;
        end
        ramp_prev = ramp;
        if (read_row != 2'b00 && first_rr < 0) first_rr = cyc;
        if (held && !(pif.valid && pif.data == held_data && pif.last == held_last)) hold_bad++;
        pif.ready = !(pif.valid && n_xfer == stall_px && stall_left > 0);
        if (!pif.ready) stall_left--;
        held = pif.valid && !pif.ready;
        held_data = pif.data;
        held_last = pif.last;
        if (pif.valid && pif.ready) begin
            if (n_xfer < 4) begin
                xdata[n_xfer] = pif.data;
                xlast[n_xfer] = pif.last;
                xcyc[n_xfer] = cyc;
            end
            n_xfer++;
        end
    end
    task automatic clear_mon(input int spx, input int sn);
        erase_n = 0; expose_n = 0; n_xfer = 0; onehot_bad = 0; hold_bad = 0;
        first_ramp = -1; first_rr = -1; rises = 0; rise_bad = 0;
        xlast = 4'h0; held = 1'b0; stall_px = spx; stall_left = sn;
    endtask
    task automatic run_frame(input vec_t v);
        logic [7:0] e[4];
        e[0] = v.e0; e[1] = v.e1; e[2] = v.e2; e[3] = v.e3;
        r0 = v.r0;
        r1 = v.r1;
        @(posedge clk);
        clear_mon(v.spx, v.sn);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({v.name, " start->erase,busy"}, int'({erase, busy}), 3);
        for (int i = 0; i < 3000 && !(n_xfer >= 4 && !busy); i++) @(negedge clk);
        chk({v.name, " frame done"}, int'(n_xfer >= 4 && !busy), 1);
        chk({v.name, " transfers"}, n_xfer, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("%s pix%0d", v.name, i), int'(xdata[i]), int'(e[i]));
        chk({v.name, " pix_last"}, int'(xlast), 8);
        chk({v.name, " row gap"}, xcyc[2] - xcyc[1], 3);
        chk({v.name, " hold stable"}, hold_bad, 0);
        chk({v.name, " read_row onehot"}, onehot_bad, 0);
        chk({v.name, " erase cycles"}, erase_n, 5);
        chk({v.name, " expose cycles"}, expose_n, 255);
        chk({v.name, " ramp rises"}, rises, 256);
        chk({v.name, " counter at rises"}, rise_bad, 0);
        chk({v.name, " convert length"}, first_rr - first_ramp, 512);
        chk({v.name, " counter final"}, int'(counter), 255);
        chk({v.name, " idle outputs"}, int'({ramp, read_row, pif.valid, pif.last}), 0);
    endtask
    initial begin
        vecs[0] = '{"plain", 16'hB0A0, 16'hD0C0, -1, 0, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
        vecs[1] = '{"stall_px1", 16'hB0A0, 16'hD0C0, 1, 3, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
        vecs[2] = '{"stall_last", 16'h0201, 16'h0403, 3, 2, 8'h01, 8'h02, 8'h03, 8'h04};
        vecs[3] = '{"stall_first", 16'hFF00, 16'h55AA, 0, 1, 8'h00, 8'hFF, 8'hAA, 8'h55};
        repeat (3) @(negedge clk);
        chk("reset outputs", outs_now(), 0);
        reset_n = 1'b1;
        begin
            int idle_bad;
            idle_bad = 0;
            repeat (100) begin
                @(negedge clk);
                if (outs_now() != 0) idle_bad++;
            end
            chk("idle 100 cycles", idle_bad, 0);
        end
        for (int k = 0; k < 4; k++) run_frame(vecs[k]);
        @(posedge clk);
        clear_mon(-1, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && counter != 8'd100; i++) @(negedge clk);
        chk("reach counter 100", int'(counter), 100);
        #2 reset_n = 1'b0;
        #1 chk("async reset mid-convert", outs_now(), 0);
        @(negedge clk);
        chk("held in reset", outs_now(), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle after reset", int'(busy), 0);
        run_frame('{"post_reset", 16'hB0A0, 16'hD0C0, -1, 0, 8'hA0, 8'hB0, 8'hC0, 8'hD0});
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
